vx_mul_pipe: RTL and testbench
==============================

Name: vx_mul_pipe

Overview:
- Pipelined, parametrised integer multiplier: successor to the combinational Wallace-tree multiplier.
- Adds the following:
  - valid/ready handshake with backpressure.
  - Configurable latency.
  - Signed, unsigned and mixed-sign operand modes.
  - Low-half or high-half result select.
  - Tag passthrough.
- Sits in the ALU/MUL functional unit and serves RISC-V MUL, MULH, MULHSU and MULHU.
- Datapath: partial products → CSA tree → Kogge-Stone CPA, with a register cut between the tree and the CPA.

Parameters:
- N, 32: operand width (≥4).
- LATENCY, 2: cycles from an accepted input to valid output (1..4).
- TAG_W, 8: width of the sideband tag carried alongside the operation (≥1).
- CPA_KS, 1: 1 = Kogge-Stone final adder; 0 = behavioural adder.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: reset; asynchronous, active-low.
- valid_in, in, 1: input operation valid.
- ready_in, out, 1: block can accept an input this cycle.
- a, in, N: operand A.
- b, in, N: operand B.
- mode, in, 2: mul_mode_t; 0 = UU, 1 = SS, 2 = SU (A signed, B unsigned), 3 = reserved, treated as UU.
- high, in, 1: 1 = return product[2N-1:N]; 0 = return product[N-1:0].
- tag_in, in, TAG_W: sideband tag.
- valid_out, out, 1: result valid.
- ready_out, in, 1: consumer accepts the result.
- result, out, N: selected product half.
- tag_out, out, TAG_W: tag of the operation carried on result.

Behaviour:
- Arithmetic:
  - Each operand is extended to N+1 bits: sign bit if that operand is signed under mode, else 0.
  - The (N+1)x(N+1) product is formed and truncated to 2N bits, so the result is exact two's-complement for all modes.
- Pipeline:
  - LATENCY slots, each holding valid + data + tag.
  - stall = valid_out & ~ready_out.
  - ready_in = ~stall, so the pipeline also accepts when the last slot is empty or draining.
  - All slots advance when ~stall; no slot changes when stall.
  - A bubble (valid_in = 0 or ready_in = 0) propagates as valid = 0.
- Throughput: 1 op/cycle with no stall. Latency is exactly LATENCY cycles.
- Stage mapping for LATENCY = 1: PP generation, CSA, CPA and half-select are all combinational into one register.
- Stage mapping for LATENCY ≥ 2:
  - Slot 0 registers CSA sum/carry (2N each), plus high and tag.
  - Slot 1 registers the CPA output with the half selected.
  - Slots 2..LATENCY-1 are pure delay.
- result/tag_out are driven from the last slot. They hold stable while valid_out = 1 and ready_out = 0.
- Handshake rules:
  - Input is consumed when valid_in & ready_in.
  - Output is consumed when valid_out & ready_out.
  - Consume-out and accept-in in the same cycle is legal: full throughput is sustained with no bubble.
- Reset (asynchronous assert, synchronous-safe deassert via the existing reset conventions):
  - All slot valids = 0 → valid_out = 0.
  - Data/tag registers are cleared to 0, so result = 0 and tag_out = 0.
  - Reset mid-operation discards all in-flight operations; no result is emitted for them.
  - ready_in = 1 from the first cycle after reset deassert.
- Boundary cases:
  - N-bit minimum-negative × minimum-negative in SS mode: high half = 2^(N-2), low = 0.
  - mode 3 yields identical results to mode 0.

Optional Feature:
- Macro: VX_MUL_PIPE_PERF_EN.
- Defined:
  - Adds output port perf_stall_cycles [31:0], counting cycles with stall = 1.
  - The counter saturates at 0xFFFFFFFF and resets to 0 on reset_n.
- Undefined: the port and counter are absent. Datapath behaviour is identical either way.

Decomposition:
- Package vx_mul_pkg:
  - mul_mode_t enum (MUL_UU = 0, MUL_SS = 1, MUL_SU = 2).
  - Constant MUL_MAX_LATENCY = 4.
  - Function mul_sign_ext(operand, is_signed).
- Sub-module vx_mul_pipe_slot:
  - Parameterised width W; enable-gated valid + payload register with asynchronous active-low clear.
  - Instantiated LATENCY times.
  - Existing CSA tree and KS adder are reused unchanged.

Test Plan:
- N = 32, LATENCY = 2, UU:
  - a = 0xFFFFFFFF, b = 0xFFFFFFFF, high = 1 → result 0xFFFFFFFE, 2 cycles after accept.
  - Same with high = 0 → result 0x00000001.
- SS, a = 0xFFFFFFFF (-1), b = 0x00000002, high = 1 → result 0xFFFFFFFF. SU with the same operands, high = 1 → result 0xFFFFFFFF. UU with the same operands, high = 1 → result 0x00000001.
- SS, a = b = 0x80000000, high = 1 → result 0x40000000; high = 0 → result 0x00000000.
- Back-to-back stream of 8 ops, tags 0..7, ready_out = 1: valid_out is continuous for 8 cycles, tags arrive in order, no bubbles.
- ready_out = 0 for 5 cycles with the pipeline full:
  - ready_in = 0 while valid_out = 1.
  - result/tag_out are held constant.
  - On ready_out = 1 all results drain in order with none lost or duplicated.
  - With VX_MUL_PIPE_PERF_EN, perf_stall_cycles = 5.
- Assert reset_n = 0 with 2 ops in flight → valid_out = 0 and result = 0 immediately; after release, ready_in = 1 and no stale result appears.

Source files
------------

// File: rtl/vx_mul_pkg.sv
// rtl/vx_mul_pkg.sv - operand modes, limits and helpers shared by the pipelined multiplier
package vx_mul_pkg;

   typedef enum logic [1:0] {
      MUL_UU   = 2'd0,
      MUL_SS   = 2'd1,
      MUL_SU   = 2'd2,
      MUL_RSVD = 2'd3
   } mul_mode_t;

   localparam int MUL_MAX_LATENCY = 4;

   // Extension bit placed above an operand's MSB when widening it to N+1 bits
   function automatic logic mul_sign_ext(input logic operand, input logic is_signed);
      return operand & is_signed;
   endfunction

   // Operand A is signed for MULH (SS) and MULHSU (SU); reserved mode falls back to UU
   function automatic logic mul_a_signed(input mul_mode_t mode);
      return (mode == MUL_SS) || (mode == MUL_SU);
   endfunction

   // Operand B is signed only for MULH (SS)
   function automatic logic mul_b_signed(input mul_mode_t mode);
      return (mode == MUL_SS);
   endfunction

   // Number of 3:2 compressor levels needed to reduce 'rows' rows down to two
   function automatic int mul_csa_levels(input int rows);
      int cnt;
      int lv;
      cnt = rows;
      lv  = 0;
      while (cnt > 2) begin
         cnt = 2 * (cnt / 3) + (cnt % 3);
         lv  = lv + 1;
      end
      return lv;
   endfunction

endpackage

// File: rtl/vx_mul_pipe_slot.sv
// rtl/vx_mul_pipe_slot.sv - one pipeline slot: enable-gated valid + payload register
module vx_mul_pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_en,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Slot advances only when the pipeline is not stalled; reset clears valid and payload
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/vx_mul_pipe.sv
// rtl/vx_mul_pipe.sv - pipelined UU/SS/SU multiplier with handshake and tag; VX_MUL_PIPE_PERF_EN adds a stall counter
module vx_mul_pipe
   import vx_mul_pkg::*;
#(
   parameter int N       = 32,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 8,
   parameter int CPA_KS  = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic [1:0]       mode,
   input  logic             high,
   input  logic [TAG_W-1:0] tag_in,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [N-1:0]     result,
   output logic [TAG_W-1:0] tag_out
`ifdef VX_MUL_PIPE_PERF_EN
   ,
   output logic [31:0]      perf_stall_cycles
`endif
);

   localparam int P_W      = 2 * N;
   localparam int P_ROWS   = N + 2;
   localparam int P_LEVELS = mul_csa_levels(P_ROWS);
   localparam int W_RES    = TAG_W + N;
   localparam int W_S0     = 1 + TAG_W + 2 * P_W;

   if (LATENCY < 1 || LATENCY > MUL_MAX_LATENCY) begin : g_bad_latency
      $error("vx_mul_pipe: LATENCY out of range");
   end

   mul_mode_t        w_mode;
   logic             w_a_ext;
   logic             w_b_ext;
   logic [P_W-1:0]   w_a2;
   logic [P_W-1:0]   w_pp [P_ROWS];
   logic [P_W-1:0]   w_csa_sum;
   logic [P_W-1:0]   w_csa_carry;
   logic [P_W-1:0]   w_cpa_x;
   logic [P_W-1:0]   w_cpa_y;
   logic [P_W-1:0]   w_cpa_sum;
   logic             w_cpa_hi;
   logic [N-1:0]     w_sel;
   logic             w_stall;
   logic             w_adv;
   logic             w_last_vld;
   logic [W_RES-1:0] w_last_res;

   assign w_mode  = mul_mode_t'(mode);
   assign w_a_ext = mul_sign_ext(a[N-1], mul_a_signed(w_mode));
   assign w_b_ext = mul_sign_ext(b[N-1], mul_b_signed(w_mode));
   // A widened to N+1 bits, then sign-extended to the 2N-bit product width
   assign w_a2    = {{N{w_a_ext}}, a};

   // Partial products: N plain rows, the negatively weighted B extension bit as ~row + 1
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_pp[i] = b[i] ? (w_a2 << i) : '0;
      end
      w_pp[N]   = w_b_ext ? ~(w_a2 << N) : '0;
      w_pp[N+1] = {{(P_W-1){1'b0}}, w_b_ext};
   end

   // Wallace-style CSA tree: each level compresses groups of three rows into sum + carry
   always_comb begin : csa_tree
      logic [P_W-1:0] cur [P_ROWS];
      logic [P_W-1:0] nxt [P_ROWS];
      int cnt;
      int ncnt;
      cur = w_pp;
      cnt = P_ROWS;
      for (int lv = 0; lv < P_LEVELS; lv++) begin
         for (int r = 0; r < P_ROWS; r++) begin
            nxt[r] = '0;
         end
         ncnt = 0;
         for (int g = 0; g + 2 < P_ROWS; g += 3) begin
            if (g + 2 < cnt) begin
               nxt[ncnt]   = cur[g] ^ cur[g+1] ^ cur[g+2];
               nxt[ncnt+1] = ((cur[g] & cur[g+1]) | (cur[g] & cur[g+2]) | (cur[g+1] & cur[g+2])) << 1;
               ncnt        = ncnt + 2;
            end
         end
         for (int r = 0; r < P_ROWS; r++) begin
            if (r >= cnt - (cnt % 3) && r < cnt) begin
               nxt[ncnt] = cur[r];
               ncnt      = ncnt + 1;
            end
         end
         cur = nxt;
         cnt = ncnt;
      end
      w_csa_sum   = cur[0];
      w_csa_carry = cur[1];
   end

   if (CPA_KS != 0) begin : g_cpa_ks
      // Kogge-Stone carry-propagate adder: log2(2N) prefix levels of generate/propagate
      always_comb begin : ks_add
         logic [P_W-1:0] kg;
         logic [P_W-1:0] kp;
         logic [P_W-1:0] kg_n;
         logic [P_W-1:0] kp_n;
         kg = w_cpa_x & w_cpa_y;
         kp = w_cpa_x ^ w_cpa_y;
         for (int d = 1; d < P_W; d = d * 2) begin
            kg_n = kg;
            kp_n = kp;
            for (int i = d; i < P_W; i++) begin
               kg_n[i] = kg[i] | (kp[i] & kg[i-d]);
               kp_n[i] = kp[i] & kp[i-d];
            end
            kg = kg_n;
            kp = kp_n;
         end
         w_cpa_sum = (w_cpa_x ^ w_cpa_y) ^ {kg[P_W-2:0], 1'b0};
      end
   end else begin : g_cpa_beh
      assign w_cpa_sum = w_cpa_x + w_cpa_y;
   end

   assign w_sel   = w_cpa_hi ? w_cpa_sum[P_W-1:N] : w_cpa_sum[N-1:0];

   // The whole pipe freezes only while the last slot holds a result nobody takes
   assign w_stall = valid_out & ~ready_out;
   assign w_adv   = ~w_stall;

   if (LATENCY == 1) begin : g_lat1
      assign w_cpa_x  = w_csa_sum;
      assign w_cpa_y  = w_csa_carry;
      assign w_cpa_hi = high;

      vx_mul_pipe_slot #(.W(W_RES)) u_slot0 (
         .clk     (clk),
         .reset_n (reset_n),
         .i_en    (w_adv),
         .i_valid (valid_in),
         .i_data  ({tag_in, w_sel}),
         .o_valid (w_last_vld),
         .o_data  (w_last_res)
      );
   end else begin : g_latn
      logic             w_s0_vld;
      logic [W_S0-1:0]  w_s0_q;
      logic [TAG_W-1:0] w_s0_tag;
      logic             w_vld [LATENCY-1:1];
      logic [W_RES-1:0] w_dat [LATENCY-1:1];

      // Slot 0 cuts between the CSA tree and the CPA
      vx_mul_pipe_slot #(.W(W_S0)) u_slot0 (
         .clk     (clk),
         .reset_n (reset_n),
         .i_en    (w_adv),
         .i_valid (valid_in),
         .i_data  ({high, tag_in, w_csa_sum, w_csa_carry}),
         .o_valid (w_s0_vld),
         .o_data  (w_s0_q)
      );

      assign w_cpa_hi = w_s0_q[W_S0-1];
      assign w_s0_tag = w_s0_q[W_S0-2 -: TAG_W];
      assign w_cpa_x  = w_s0_q[2*P_W-1 -: P_W];
      assign w_cpa_y  = w_s0_q[P_W-1:0];

      // Slot 1 holds the selected product half
      vx_mul_pipe_slot #(.W(W_RES)) u_slot1 (
         .clk     (clk),
         .reset_n (reset_n),
         .i_en    (w_adv),
         .i_valid (w_s0_vld),
         .i_data  ({w_s0_tag, w_sel}),
         .o_valid (w_vld[1]),
         .o_data  (w_dat[1])
      );

      // Remaining slots only add delay
      for (genvar k = 2; k < LATENCY; k++) begin : g_delay
         vx_mul_pipe_slot #(.W(W_RES)) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .i_en    (w_adv),
            .i_valid (w_vld[k-1]),
            .i_data  (w_dat[k-1]),
            .o_valid (w_vld[k]),
            .o_data  (w_dat[k])
         );
      end

      assign w_last_vld = w_vld[LATENCY-1];
      assign w_last_res = w_dat[LATENCY-1];
   end

   assign ready_in  = ~w_stall;
   assign valid_out = w_last_vld;
   assign result    = w_last_res[N-1:0];
   assign tag_out   = w_last_res[W_RES-1:N];

`ifdef VX_MUL_PIPE_PERF_EN
   logic [31:0] r_perf_stall;

   // Saturating count of cycles in which the output is blocked
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_stall <= '0;
      end else if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
         r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_vx_mul_pipe.sv
// tb/tb_vx_mul_pipe.sv - directed vector bench for vx_mul_pipe (N=32, LATENCY=2)
module tb_vx_mul_pipe;

   localparam int N   = 32;
   localparam int LAT = 2;
   localparam int TW  = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          valid_in;
   logic          ready_in;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic [1:0]    mode;
   logic          high;
   logic [TW-1:0] tag_in;
   logic          valid_out;
   logic          ready_out;
   logic [N-1:0]  result;
   logic [TW-1:0] tag_out;
`ifdef VX_MUL_PIPE_PERF_EN
   logic [31:0]   perf_stall_cycles;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic        high;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [16];

   always #5 clk = ~clk;

   vx_mul_pipe #(.N(N), .LATENCY(LAT), .TAG_W(TW), .CPA_KS(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .high      (high),
      .tag_in    (tag_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .result    (result),
      .tag_out   (tag_out)
`ifdef VX_MUL_PIPE_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      int last;
      int nvalid;
      int exp_tag;
      int sent;
      int got;
      int nstall;
      int stale;

      vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE};
      vecs[1]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
      vecs[2]  = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF};
      vecs[3]  = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF};
      vecs[4]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001};
      vecs[5]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000};
      vecs[6]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000};
      vecs[7]  = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE};
      vecs[8]  = '{2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001};
      vecs[9]  = '{2'd1, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
      vecs[10] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
      vecs[11] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
      vecs[12] = '{2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF};
      vecs[13] = '{2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h8000_0000};
      vecs[14] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'hC000_0000};
      vecs[15] = '{2'd3, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000};

      reset_n   = 1'b0;
      valid_in  = 1'b0;
      a         = '0;
      b         = '0;
      mode      = 2'd0;
      high      = 1'b0;
      tag_in    = '0;
      ready_out = 1'b1;
      tick();
      tick();
      tick();
      check("rst_valid_out", valid_out, 0);
      check("rst_result", result, 0);
      check("rst_tag_out", tag_out, 0);
      reset_n = 1'b1;
      tick();
      check("rst_ready_in", ready_in, 1);

      // Table vectors, one op at a time, checking exact two-cycle latency
      for (int i = 0; i < 16; i++) begin
         mode     = vecs[i].mode;
         a        = vecs[i].a;
         b        = vecs[i].b;
         high     = vecs[i].high;
         tag_in   = TW'(8'h40 + i);
         valid_in = 1'b1;
         check($sformatf("vec%0d_ready_in", i), ready_in, 1);
         tick();
         valid_in = 1'b0;
         check($sformatf("vec%0d_early_valid", i), valid_out, 0);
         tick();
         check($sformatf("vec%0d_valid", i), valid_out, 1);
         check($sformatf("vec%0d_result", i), result, vecs[i].exp);
         check($sformatf("vec%0d_tag", i), tag_out, 64'(8'h40 + i));
      end
      tick();

      // Back-to-back stream of 8 ops: output must be continuous and in order
      first   = -1;
      last    = -1;
      nvalid  = 0;
      exp_tag = 0;
      for (int c = 0; c < 12; c++) begin
         valid_in = (c < 8);
         a        = N'(c + 1);
         b        = 32'd3;
         mode     = 2'd0;
         high     = 1'b0;
         tag_in   = TW'(c);
         tick();
         if (valid_out) begin
            if (first < 0) first = c;
            last = c;
            nvalid++;
            check($sformatf("stream%0d_tag", exp_tag), tag_out, exp_tag);
            check($sformatf("stream%0d_result", exp_tag), result, (exp_tag + 1) * 3);
            exp_tag++;
         end
      end
      valid_in = 1'b0;
      check("stream_count", nvalid, 8);
      check("stream_first", first, 1);
      check("stream_gapless", last - first + 1, 8);

      // Backpressure: output blocked for 5 cycles with the pipe full
      sent   = 0;
      got    = 0;
      nstall = 0;
      for (int c = 0; c < 16; c++) begin
         ready_out = !(c >= 2 && c < 7);
         valid_in  = (sent < 4);
         a         = N'(10 + sent);
         b         = 32'd5;
         mode      = 2'd0;
         high      = 1'b0;
         tag_in    = TW'(10 + sent);
         #1;
         if (valid_out && !ready_out) begin
            nstall++;
            check($sformatf("stall%0d_ready_in", c), ready_in, 0);
            check($sformatf("stall%0d_hold_tag", c), tag_out, 10);
            check($sformatf("stall%0d_hold_result", c), result, 50);
         end
         if (valid_out && ready_out) begin
            check($sformatf("drain%0d_tag", got), tag_out, 10 + got);
            check($sformatf("drain%0d_result", got), result, (10 + got) * 5);
            got++;
         end
         if (valid_in && ready_in) sent++;
         tick();
      end
      valid_in  = 1'b0;
      ready_out = 1'b1;
      check("stall_cycles_seen", nstall, 5);
      check("drain_count", got, 4);
      check("drain_sent", sent, 4);
`ifdef VX_MUL_PIPE_PERF_EN
      check("perf_stall_cycles", perf_stall_cycles, 5);
`endif

      // Reset with two ops in flight discards both
      valid_in = 1'b1;
      a        = 32'd7;
      b        = 32'd9;
      tag_in   = 8'd20;
      tick();
      a        = 32'd8;
      tag_in   = 8'd21;
      tick();
      valid_in = 1'b0;
      check("inflight_valid", valid_out, 1);
      check("inflight_result", result, 63);
      reset_n = 1'b0;
      #1;
      check("midrst_valid_out", valid_out, 0);
      check("midrst_result", result, 0);
      check("midrst_tag_out", tag_out, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("postrst_ready_in", ready_in, 1);
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         if (valid_out) stale++;
         tick();
      end
      check("postrst_no_stale", stale, 0);

      // Pipe is usable again after reset
      valid_in = 1'b1;
      a        = 32'd6;
      b        = 32'd7;
      tag_in   = 8'd22;
      tick();
      valid_in = 1'b0;
      tick();
      check("postrst_valid", valid_out, 1);
      check("postrst_result", result, 42);
      check("postrst_tag", tag_out, 22);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
